power_spectrum_streamer: RTL and testbench

- Sits between the FFT core and the bank of triangular mel filters.
- Converts the FFT's complex bin stream into the per-bin (k, power) stream that every triangular filter consumes on its shared power/k inputs.
- Emits only the positive-frequency half of each frame, plus a frame-done strobe so downstream logic knows when to sample the filter outputs.

---
 rtl/fpga_audio_pkg.sv | 23 ++
 rtl/complex_mag_sq.sv | 74 +++++++
 rtl/power_spectrum_streamer.sv | 132 +++++++++++++
 tb/tb_power_spectrum_streamer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fpga_audio_pkg.sv
// Shared constants and types for the FFT -> mel filter bank path.
// FFT_SIZE / NUM_BINS / K_WIDTH / PWR_WIDTH are common to the power spectrum
// streamer and the triangular filters that consume its (k, power) stream.
package fpga_audio_pkg;

  localparam int unsigned FFT_SIZE  = 1024;
  localparam int unsigned NUM_BINS  = FFT_SIZE / 2;
  localparam int unsigned K_WIDTH   = $clog2(NUM_BINS);
  localparam int unsigned PWR_WIDTH = 32;

  // One beat of the per-bin power stream as seen by the filters.
  typedef struct packed {
    logic [K_WIDTH-1:0]   k;
    logic [PWR_WIDTH-1:0] power;
    logic                 valid;
  } bin_power_t;

  typedef enum logic {
    StSync = 1'b0,
    StRun  = 1'b1
  } stream_state_e;

endpackage

// File: rtl/complex_mag_sq.sv
// Two-stage |z|^2 pipeline: stage 1 registers re*re and im*im, stage 2
// registers their zero-extended unsigned sum. A tag field rides alongside.
// When a beat is not valid, products, sum and tag are all forced to zero.
//
// Ports:
//   clk_in    - clock
//   rst_in    - synchronous active-low reset
//   valid_in  - beat valid
//   re_in     - signed real part
//   im_in     - signed imaginary part
//   tag_in    - side-band bits carried with the beat
//   valid_out - pipelined valid
//   power_out - re^2 + im^2, zero when not valid
//   tag_out   - pipelined tag, zero when not valid
module complex_mag_sq #(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned TAG_WIDTH = 1,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        valid_in,
  input  logic signed [IN_WIDTH-1:0]  re_in,
  input  logic signed [IN_WIDTH-1:0]  im_in,
  input  logic        [TAG_WIDTH-1:0] tag_in,
  output logic                        valid_out,
  output logic        [OUT_WIDTH-1:0] power_out,
  output logic        [TAG_WIDTH-1:0] tag_out
);

  localparam int unsigned ProdW = 2 * IN_WIDTH;

  logic signed [ProdW-1:0] w_re_ext, w_im_ext, w_re_sq, w_im_sq;
  logic        [OUT_WIDTH-1:0] w_sum;

  logic [ProdW-1:0]     r_re_sq, r_im_sq;
  logic                 r_vld1, r_vld2;
  logic [TAG_WIDTH-1:0] r_tag1, r_tag2;
  logic [OUT_WIDTH-1:0] r_power;

  assign w_re_ext = {{IN_WIDTH{re_in[IN_WIDTH-1]}}, re_in};
  assign w_im_ext = {{IN_WIDTH{im_in[IN_WIDTH-1]}}, im_in};
  assign w_re_sq  = w_re_ext * w_re_ext;
  assign w_im_sq  = w_im_ext * w_im_ext;

  // Squares are non-negative, so the raw bits are already the unsigned value;
  // the worst case (-2^(W-1))^2 * 2 = 2^(2W-1) still fits without carry-out.
  assign w_sum = OUT_WIDTH'(r_re_sq) + OUT_WIDTH'(r_im_sq);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_re_sq <= '0;
      r_im_sq <= '0;
      r_vld1  <= 1'b0;
      r_tag1  <= '0;
      r_power <= '0;
      r_vld2  <= 1'b0;
      r_tag2  <= '0;
    end else begin
      r_vld1  <= valid_in;
      r_re_sq <= valid_in ? w_re_sq : '0;
      r_im_sq <= valid_in ? w_im_sq : '0;
      r_tag1  <= valid_in ? tag_in : '0;
      r_vld2  <= r_vld1;
      r_power <= r_vld1 ? w_sum : '0;
      r_tag2  <= r_vld1 ? r_tag1 : '0;
    end
  end

  assign valid_out = r_vld2;
  assign power_out = r_power;
  assign tag_out   = r_tag2;

endmodule

// File: rtl/power_spectrum_streamer.sv
// Converts the FFT's complex bin stream into the (k, power) stream shared by
// the triangular mel filters. Only bins 0..NUM_BINS-1 of each frame are
// forwarded; a frame-done strobe accompanies bin NUM_BINS-1. Frame alignment
// comes from fft_last_in: nothing is emitted until a last has been seen, and
// an early last resynchronises the bin counter and sets a sticky error.
//
// A forwarded beat is captured at edge N, squared at N+1 and summed at N+2,
// so it is visible on the outputs right after edge N+2.
//
// Ports:
//   clk_in          - system clock
//   rst_in          - synchronous active-low reset
//   fft_valid_in    - FFT beat valid (no backpressure)
//   fft_re_in       - signed real part of current bin
//   fft_im_in       - signed imaginary part of current bin
//   fft_last_in     - final beat of a frame
//   power_out       - unsigned re^2 + im^2, zero when idle
//   k_out           - bin index of power_out, zero when idle
//   power_valid_out - power_out/k_out valid
//   frame_done_out  - pulse with the k_out = NUM_BINS-1 beat
//   sync_err_out    - sticky: last seen at a bin other than FFT_SIZE-1
module power_spectrum_streamer #(
  parameter int unsigned FFT_SIZE = fpga_audio_pkg::FFT_SIZE,
  parameter int unsigned NUM_BINS = fpga_audio_pkg::NUM_BINS,
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned K_WIDTH  = fpga_audio_pkg::K_WIDTH
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  fft_valid_in,
  input  logic signed [IN_WIDTH-1:0]            fft_re_in,
  input  logic signed [IN_WIDTH-1:0]            fft_im_in,
  input  logic                                  fft_last_in,
  output logic [fpga_audio_pkg::PWR_WIDTH-1:0]  power_out,
  output logic [K_WIDTH-1:0]                    k_out,
  output logic                                  power_valid_out,
  output logic                                  frame_done_out,
  output logic                                  sync_err_out
);

  import fpga_audio_pkg::*;

  localparam int unsigned CntW = $clog2(FFT_SIZE);
  localparam logic [CntW-1:0] LastBin = CntW'(FFT_SIZE - 1);
  localparam logic [CntW-1:0] FwdBins = CntW'(NUM_BINS);
  localparam logic [CntW-1:0] DoneBin = CntW'(NUM_BINS - 1);

  stream_state_e r_state, w_state_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic            r_sync_err, w_sync_err_nxt;
  logic            w_fwd, w_done;

  // Capture register in front of the squaring pipeline.
  logic                       r_in_vld, r_in_done;
  logic signed [IN_WIDTH-1:0] r_in_re, r_in_im;
  logic [K_WIDTH-1:0]         r_in_k;

  logic [K_WIDTH:0] w_tag_out;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sync_err_nxt = r_sync_err;
    w_fwd          = 1'b0;
    w_done         = 1'b0;
    if (fft_valid_in) begin
      case (r_state)
        StSync: begin
          if (fft_last_in) begin
            w_state_nxt = StRun;
            w_cnt_nxt   = '0;
          end
        end
        StRun: begin
          w_fwd  = (r_cnt < FwdBins);
          w_done = w_fwd && (r_cnt == DoneBin);
          if (fft_last_in) begin
            // Always realign on a last; flag it if it came early.
            w_cnt_nxt = '0;
            if (r_cnt != LastBin) w_sync_err_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = StSync;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= StSync;
      r_cnt      <= '0;
      r_sync_err <= 1'b0;
      r_in_vld   <= 1'b0;
      r_in_done  <= 1'b0;
      r_in_re    <= '0;
      r_in_im    <= '0;
      r_in_k     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sync_err <= w_sync_err_nxt;
      r_in_vld   <= w_fwd;
      r_in_done  <= w_done;
      r_in_re    <= w_fwd ? fft_re_in : '0;
      r_in_im    <= w_fwd ? fft_im_in : '0;
      r_in_k     <= w_fwd ? r_cnt[K_WIDTH-1:0] : '0;
    end
  end

  complex_mag_sq #(
    .IN_WIDTH  (IN_WIDTH),
    .TAG_WIDTH (K_WIDTH + 1),
    .OUT_WIDTH (PWR_WIDTH)
  ) u_mag_sq (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .valid_in  (r_in_vld),
    .re_in     (r_in_re),
    .im_in     (r_in_im),
    .tag_in    ({r_in_done, r_in_k}),
    .valid_out (power_valid_out),
    .power_out (power_out),
    .tag_out   (w_tag_out)
  );

  assign k_out          = w_tag_out[K_WIDTH-1:0];
  assign frame_done_out = w_tag_out[K_WIDTH];
  assign sync_err_out   = r_sync_err;

endmodule

// File: tb/tb_power_spectrum_streamer.sv
// Self-checking bench for power_spectrum_streamer. A frame-level reference
// model (synced flag, bin number, sticky error) predicts each output beat,
// which is compared two clock edges after the beat is accepted.
module tb_power_spectrum_streamer;

  localparam int FFT_N = 1024;
  localparam int NBINS = 512;

  logic               clk_in = 1'b0;
  logic               rst_in;
  logic               fft_valid_in;
  logic signed [15:0] fft_re_in;
  logic signed [15:0] fft_im_in;
  logic               fft_last_in;
  logic [31:0]        power_out;
  logic [8:0]         k_out;
  logic               power_valid_out;
  logic               frame_done_out;
  logic               sync_err_out;

  always #5 clk_in = ~clk_in;

  power_spectrum_streamer dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .fft_valid_in    (fft_valid_in),
    .fft_re_in       (fft_re_in),
    .fft_im_in       (fft_im_in),
    .fft_last_in     (fft_last_in),
    .power_out       (power_out),
    .k_out           (k_out),
    .power_valid_out (power_valid_out),
    .frame_done_out  (frame_done_out),
    .sync_err_out    (sync_err_out)
  );

  typedef struct {
    logic        valid;
    logic [31:0] power;
    logic [8:0]  k;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  exp_t idle_beat;
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model state.
  bit m_synced;
  int m_bin;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk("valid", 32'(power_valid_out), 32'(e.valid));
    chk("power", power_out, e.power);
    chk("k", 32'(k_out), 32'(e.k));
    chk("frame_done", 32'(frame_done_out), 32'(e.done));
    chk("sync_err", 32'(sync_err_out), 32'(m_err));
  endtask

  task automatic step(input logic v, input logic signed [15:0] re,
                      input logic signed [15:0] im, input logic l);
    exp_t   e;
    int     ri, ii;
    longint p;
    e = idle_beat;
    rst_in       = 1'b1;
    fft_valid_in = v;
    fft_re_in    = re;
    fft_im_in    = im;
    fft_last_in  = l;
    if (v) begin
      if (!m_synced) begin
        if (l) begin
          m_synced = 1'b1;
          m_bin    = 0;
        end
      end else begin
        if (m_bin < NBINS) begin
          ri      = re;
          ii      = im;
          p       = longint'(ri) * ri + longint'(ii) * ii;
          e.valid = 1'b1;
          e.power = p[31:0];
          e.k     = 9'(m_bin);
          e.done  = (m_bin == NBINS - 1);
        end
        if (l) begin
          if (m_bin != FFT_N - 1) m_err = 1'b1;
          m_bin = 0;
        end else begin
          m_bin = (m_bin + 1) % FFT_N;
        end
      end
    end
    exp_q.push_back(e);
    @(posedge clk_in);
    #1;
    check_out(exp_q.pop_front());
  endtask

  task automatic reset_step();
    rst_in       = 1'b0;
    fft_valid_in = 1'($urandom);
    fft_re_in    = 16'($urandom);
    fft_im_in    = 16'($urandom);
    fft_last_in  = 1'($urandom);
    m_synced     = 1'b0;
    m_bin        = 0;
    m_err        = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    check_out(idle_beat);
    exp_q.delete();
    exp_q.push_back(idle_beat);
    exp_q.push_back(idle_beat);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  // mode 0: random data with random gaps, 1: re=3 im=4, 2: bin 7 at -32768,
  // 3: re=bin im=0. The frame stops after bin last_at; rst_at aborts it.
  task automatic send_frame(input int mode, input int last_at, input int rst_at, input bit gappy);
    logic signed [15:0] re, im;
    for (int b = 0; b <= last_at; b++) begin
      if (b == rst_at) begin
        reset_step();
        return;
      end
      case (mode)
        1:       begin re = 16'sd3; im = 16'sd4; end
        2:       begin re = (b == 7) ? -16'sd32768 : 16'sd0; im = re; end
        3:       begin re = 16'(b); im = 16'sd0; end
        default: begin re = 16'($urandom); im = 16'($urandom); end
      endcase
      if (mode == 0 && $urandom_range(0, 7) == 0) idle(1);
      step(1'b1, re, im, b == last_at);
      if (gappy) step(1'b0, 16'sd0, 16'sd0, 1'b0);
    end
  endtask

  initial begin
    idle_beat.valid = 1'b0;
    idle_beat.power = '0;
    idle_beat.k     = '0;
    idle_beat.done  = 1'b0;
    rst_in       = 1'b0;
    fft_valid_in = 1'b0;
    fft_re_in    = '0;
    fft_im_in    = '0;
    fft_last_in  = 1'b0;
    m_synced     = 1'b0;
    m_bin        = 0;
    m_err        = 1'b0;

    repeat (3) reset_step();
    idle(4);

    // Unsynced frame is discarded; its last arms the next frame.
    send_frame(0, FFT_N - 1, -1, 1'b0);
    send_frame(1, FFT_N - 1, -1, 1'b0);
    idle(5);
    send_frame(2, FFT_N - 1, -1, 1'b0);
    idle(3);
    send_frame(3, FFT_N - 1, -1, 1'b1);
    idle(2);

    // Early last at bin 300, then a clean frame.
    send_frame(0, 300, -1, 1'b0);
    chk("sync_err_set", 32'(sync_err_out), 32'd1);
    send_frame(0, FFT_N - 1, -1, 1'b0);
    chk("sync_err_sticky", 32'(sync_err_out), 32'd1);

    // Reset at bin 100: next frame discarded, the one after emitted.
    send_frame(0, FFT_N - 1, 100, 1'b0);
    chk("sync_err_cleared", 32'(sync_err_out), 32'd0);
    send_frame(0, FFT_N - 1, -1, 1'b0);
    send_frame(0, FFT_N - 1, -1, 1'b0);
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
